// File: rtl/ip_checksum_ttl.sv
`default_nettype none
// ============================================================================
// Module   : ip_checksum_ttl
// Brief    : Taps the lookup datapath, checks the IPv4 header checksum, derives
//            the decremented TTL and updated checksum, and queues one result
//            per packet in a small info FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ip_checksum_ttl #(
    parameter int DATA_WIDTH           = 64,
    parameter int CTRL_WIDTH           = DATA_WIDTH / 8,
    parameter int INFO_FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    input  logic                  rd_preprocess_info,
    output logic                  ip_checksum_vld,
    output logic                  ip_checksum_is_good,
    output logic                  ip_hdr_has_options,
    output logic                  ip_ttl_is_good,
    output logic [7:0]            ip_new_ttl,
    output logic [15:0]           ip_new_checksum,
    output logic                  info_fifo_overflow
);

    localparam int c_FIFO_DEPTH = 1 << INFO_FIFO_DEPTH_BITS;
    localparam int c_INFO_W     = 27;

    localparam logic [INFO_FIFO_DEPTH_BITS:0]   c_FULL_COUNT =
        (INFO_FIFO_DEPTH_BITS + 1)'(c_FIFO_DEPTH);
    localparam logic [INFO_FIFO_DEPTH_BITS-1:0] c_PTR_ONE =
        INFO_FIFO_DEPTH_BITS'(1);

    localparam logic [1:0] c_ST_HDR      = 2'd0;
    localparam logic [1:0] c_ST_IP       = 2'd1;
    localparam logic [1:0] c_ST_FINAL    = 2'd2;
    localparam logic [1:0] c_ST_WAIT_EOP = 2'd3;

    // {is_good, has_options, ttl_is_good, new_ttl, new_checksum}
    localparam logic [c_INFO_W-1:0] c_RUNT_INFO = {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000};

    function automatic logic [15:0] f_oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [2:0]  r_word_cnt;
    logic [16:0] r_acc;
    logic [7:0]  r_ver_ihl;
    logic [7:0]  r_ttl;
    logic [7:0]  r_proto;
    logic [15:0] r_hdr_csum;
    logic        r_w4_eop;
    logic        r_prev_data;

    logic        w_is_data;
    logic        w_eop;
    logic [15:0] w_hw0, w_hw1, w_hw2, w_hw3;
    logic [15:0] w_word_sum;
    logic [15:0] w_acc_fold;
    logic [16:0] w_acc_next;

    logic        w_push_final;
    logic        w_push_runt;
    logic        w_is_good;
    logic        w_has_options;
    logic        w_ttl_is_good;
    logic [7:0]  w_new_ttl;
    logic [15:0] w_new_csum;
    logic [c_INFO_W-1:0] w_push_info;

    assign w_is_data = (in_ctrl == '0);
    // EOP is the first non-data word following a data word
    assign w_eop     = in_wr && !w_is_data && r_prev_data;

    always_comb begin
        w_hw0 = 16'h0000;
        w_hw1 = 16'h0000;
        w_hw2 = 16'h0000;
        w_hw3 = 16'h0000;
        case (r_word_cnt)
            3'd1: w_hw3 = in_data[15:0];
            3'd2, 3'd3: begin
                w_hw0 = in_data[63:48];
                w_hw1 = in_data[47:32];
                w_hw2 = in_data[31:16];
                w_hw3 = in_data[15:0];
            end
            3'd4: w_hw0 = in_data[63:48];
            default: ;
        endcase
    end

    assign w_word_sum = f_oc_add(f_oc_add(w_hw0, w_hw1), f_oc_add(w_hw2, w_hw3));
    assign w_acc_fold = r_acc[15:0] + {15'd0, r_acc[16]};
    assign w_acc_next = {1'b0, w_acc_fold} + {1'b0, w_word_sum};

    assign w_is_good     = (w_acc_fold == 16'hFFFF);
    assign w_has_options = (r_ver_ihl != 8'h45);
    assign w_ttl_is_good = (r_ttl > 8'd1);
    assign w_new_ttl     = (r_ttl == 8'd0) ? 8'd0 : (r_ttl - 8'd1);
    // Incremental update: HC' = ~(~HC + ~m + m')
    assign w_new_csum    = ~f_oc_add(f_oc_add(~r_hdr_csum, ~{r_ttl, r_proto}),
                                     {w_new_ttl, r_proto});

    assign w_push_info = w_push_final
                       ? {w_is_good, w_has_options, w_ttl_is_good, w_new_ttl, w_new_csum}
                       : c_RUNT_INFO;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push_final = 1'b0;
        w_push_runt  = 1'b0;
        case (r_state)
            c_ST_HDR: begin
                if (in_wr && w_is_data) begin
                    w_state_next = c_ST_IP;
                end
            end
            c_ST_IP: begin
                if (in_wr) begin
                    if (r_word_cnt == 3'd4) begin
                        w_state_next = c_ST_FINAL;
                    end else if (w_eop) begin
                        w_push_runt  = 1'b1;
                        w_state_next = c_ST_HDR;
                    end
                end
            end
            c_ST_FINAL: begin
                w_push_final = 1'b1;
                // A packet that already ended must not wait for another EOP
                w_state_next = (r_w4_eop || w_eop) ? c_ST_HDR : c_ST_WAIT_EOP;
            end
            c_ST_WAIT_EOP: begin
                if (w_eop) begin
                    w_state_next = c_ST_HDR;
                end
            end
            default: w_state_next = c_ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_cnt  <= 3'd0;
            r_acc       <= 17'd0;
            r_ver_ihl   <= 8'd0;
            r_ttl       <= 8'd0;
            r_proto     <= 8'd0;
            r_hdr_csum  <= 16'd0;
            r_w4_eop    <= 1'b0;
            r_prev_data <= 1'b0;
        end else begin
            if (in_wr) begin
                r_prev_data <= w_is_data;
            end
            if (r_state == c_ST_HDR) begin
                if (in_wr && w_is_data) begin
                    r_word_cnt <= 3'd1;
                    r_acc      <= 17'd0;
                    r_w4_eop   <= 1'b0;
                end
            end else if (r_state == c_ST_IP && in_wr) begin
                r_word_cnt <= r_word_cnt + 3'd1;
                r_acc      <= w_acc_next;
                case (r_word_cnt)
                    3'd1: r_ver_ihl <= in_data[15:8];
                    3'd2: begin
                        r_ttl   <= in_data[15:8];
                        r_proto <= in_data[7:0];
                    end
                    3'd3: r_hdr_csum <= in_data[63:48];
                    3'd4: r_w4_eop   <= w_eop;
                    default: ;
                endcase
            end
        end
    end

    logic [c_INFO_W-1:0]             r_mem [c_FIFO_DEPTH];
    logic [INFO_FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [INFO_FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [INFO_FIFO_DEPTH_BITS:0]   r_count;
    logic                            r_overflow;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_push_ok;
    logic [c_INFO_W-1:0] w_head;

    assign w_push    = w_push_final || w_push_runt;
    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = rd_preprocess_info && !w_empty;
    // A pop on the same edge frees the slot, so a push at full still lands
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_info;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= w_push && w_full && !w_pop;
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign ip_checksum_vld     = !w_empty;
    assign ip_checksum_is_good = w_head[26];
    assign ip_hdr_has_options  = w_head[25];
    assign ip_ttl_is_good      = w_head[24];
    assign ip_new_ttl          = w_head[23:16];
    assign ip_new_checksum     = w_head[15:0];
    assign info_fifo_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ip_checksum_ttl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_checksum_ttl
// Brief    : Self-checking bench for ip_checksum_ttl against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_checksum_ttl;

    typedef struct packed {
        logic        good;
        logic        opt;
        logic        ttl_good;
        logic [7:0]  ttl;
        logic [15:0] csum;
    } info_t;

    localparam info_t c_RUNT = {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000};

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        rd_preprocess_info;
    logic        ip_checksum_vld;
    logic        ip_checksum_is_good;
    logic        ip_hdr_has_options;
    logic        ip_ttl_is_good;
    logic [7:0]  ip_new_ttl;
    logic [15:0] ip_new_checksum;
    logic        info_fifo_overflow;

    int n_checks   = 0;
    int n_fail     = 0;
    int ovf_pulses = 0;

    logic [63:0] pkt_d [$];
    logic [7:0]  pkt_c [$];
    info_t       exp_q [$];

    ip_checksum_ttl #(
        .DATA_WIDTH          (64),
        .CTRL_WIDTH          (8),
        .INFO_FIFO_DEPTH_BITS(2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_data            (in_data),
        .in_ctrl            (in_ctrl),
        .in_wr              (in_wr),
        .rd_preprocess_info (rd_preprocess_info),
        .ip_checksum_vld    (ip_checksum_vld),
        .ip_checksum_is_good(ip_checksum_is_good),
        .ip_hdr_has_options (ip_hdr_has_options),
        .ip_ttl_is_good     (ip_ttl_is_good),
        .ip_new_ttl         (ip_new_ttl),
        .ip_new_checksum    (ip_new_checksum),
        .info_fifo_overflow (info_fifo_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (info_fifo_overflow === 1'b1) ovf_pulses++;
    end

    function automatic info_t observed();
        return {ip_checksum_is_good, ip_hdr_has_options, ip_ttl_is_good,
                ip_new_ttl, ip_new_checksum};
    endfunction

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        int unsigned s;
        s = 32'(a) + 32'(b);
        if (s > 32'hFFFF) s = s - 32'hFFFF;
        return s[15:0];
    endfunction

    function automatic info_t model(input logic [15:0] h [10], input int n_data);
        info_t       r;
        int unsigned s;
        logic [7:0]  ttl, nttl, proto;
        if (n_data <= 4) return c_RUNT;
        s = 0;
        for (int i = 0; i < 10; i++) s += 32'(h[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ttl   = h[4][15:8];
        proto = h[4][7:0];
        nttl  = (ttl == 8'd0) ? 8'd0 : ttl - 8'd1;
        r.good     = (s == 32'hFFFF);
        r.opt      = (h[0][15:12] != 4'd4) || (h[0][11:8] != 4'd5);
        r.ttl_good = (ttl > 8'd1);
        r.ttl      = nttl;
        r.csum     = ~oc_add(oc_add(~h[5], ~{ttl, proto}), {nttl, proto});
        return r;
    endfunction

    task automatic make_hdr(output logic [15:0] h [10], input logic [7:0] ver_ihl,
                            input logic [7:0] ttl, input bit good);
        int unsigned s;
        for (int i = 0; i < 10; i++) h[i] = 16'($urandom);
        h[0] = {ver_ihl, h[0][7:0]};
        h[4] = {ttl, h[4][7:0]};
        h[5] = 16'h0000;
        s = 0;
        for (int i = 0; i < 10; i++) s += 32'(h[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        h[5] = ~s[15:0];
        if (!good) h[5] = h[5] ^ (16'h0001 << $urandom_range(15, 0));
    endtask

    task automatic build_pkt(input logic [15:0] h [10], input int n_data, input int n_mh);
        logic [63:0] w;
        pkt_d.delete();
        pkt_c.delete();
        for (int i = 0; i < n_mh; i++) begin
            pkt_d.push_back({$urandom, $urandom});
            pkt_c.push_back(8'hFF);
        end
        for (int i = 0; i < n_data; i++) begin
            w = {$urandom, $urandom};
            case (i)
                1: w[15:0]  = h[0];
                2: w        = {h[1], h[2], h[3], h[4]};
                3: w        = {h[5], h[6], h[7], h[8]};
                4: w[63:48] = h[9];
                default: ;
            endcase
            pkt_d.push_back(w);
            pkt_c.push_back((i == n_data - 1) ? (8'h01 << $urandom_range(7, 0)) : 8'h00);
        end
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] c);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        @(posedge clk); #1;
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop();
        rd_preprocess_info = 1'b1;
        @(posedge clk); #1;
        rd_preprocess_info = 1'b0;
    endtask

    task automatic send_pkt(input bit gaps);
        for (int i = 0; i < pkt_d.size(); i++) begin
            if (gaps && $urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
            put(pkt_d[i], pkt_c[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        n_checks++;
        if ({ip_checksum_vld, observed(), info_fifo_overflow} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ip_checksum_vld, observed(), info_fifo_overflow});
        end
        reset = 1'b0;
        idle(2);
        n_checks++;
        if ({ip_checksum_vld, observed(), info_fifo_overflow} !== 29'h0) begin
            n_fail++;
            $display("FAIL post_reset_outputs: got %h required 0",
                     {ip_checksum_vld, observed(), info_fifo_overflow});
        end
    endtask

    task automatic test_valid();
        logic [15:0] h [10];
        info_t exp;
        h   = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
        exp = {1'b1, 1'b0, 1'b1, 8'h3F, 16'hB961};
        build_pkt(h, 8, 1);
        for (int i = 0; i < pkt_d.size(); i++) begin
            put(pkt_d[i], pkt_c[i]);
            if (i == 5) begin
                n_checks++;
                if (ip_checksum_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_latency_early: vld=%b required 0", ip_checksum_vld);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
                    n_fail++;
                    $display("FAIL valid_entry: vld=%b info=%h required vld=1 info=%h",
                             ip_checksum_vld, observed(), exp);
                end
            end
        end
        pop();
        n_checks++;
        if (ip_checksum_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pop_empty: vld=%b required 0", ip_checksum_vld);
        end
    endtask

    task automatic test_bad_checksum();
        logic [15:0] h [10];
        info_t exp;
        h   = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                16'hB862, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
        exp = {1'b0, 1'b0, 1'b1, 8'h3F, 16'hB962};
        build_pkt(h, 9, 2);
        send_pkt(1'b0);
        n_checks++;
        if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
            n_fail++;
            $display("FAIL bad_checksum: vld=%b info=%h required vld=1 info=%h",
                     ip_checksum_vld, observed(), exp);
        end
        pop();
    endtask

    task automatic test_ttl_options();
        logic [15:0] h [10];
        logic [15:0] h0s [4] = '{16'h4500, 16'h4500, 16'h4600, 16'h6500};
        logic [15:0] h4s [4] = '{16'h0111, 16'h0011, 16'h4011, 16'h4011};
        info_t exp, obs;
        for (int k = 0; k < 4; k++) begin
            h    = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                     16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
            h[0] = h0s[k];
            h[4] = h4s[k];
            exp  = model(h, 8);
            build_pkt(h, 8, 1);
            send_pkt(1'b0);
            obs = observed();
            n_checks++;
            if (ip_checksum_vld !== 1'b1 || obs !== exp) begin
                n_fail++;
                $display("FAIL ttl_opt_entry[%0d]: vld=%b info=%h required info=%h",
                         k, ip_checksum_vld, obs, exp);
            end
            n_checks++;
            if (k < 2) begin
                if ({obs.ttl_good, obs.ttl} !== 9'h000) begin
                    n_fail++;
                    $display("FAIL ttl_low[%0d]: ttl_good=%b new_ttl=%h required 0/00",
                             k, obs.ttl_good, obs.ttl);
                end
            end else if (obs.opt !== 1'b1) begin
                n_fail++;
                $display("FAIL has_options[%0d]: got %b required 1", k, obs.opt);
            end
            pop();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] h [10];
        info_t exp;
        int    n, ovf_base;
        ovf_base = ovf_pulses;
        exp_q.delete();
        for (int p = 0; p < 5; p++) begin
            make_hdr(h, 8'h45, 8'($urandom_range(255, 2)), 1'b1);
            n = $urandom_range(10, 7);
            exp_q.push_back(model(h, n));
            build_pkt(h, n, 1);
            send_pkt(1'b0);
        end
        idle(2);
        n_checks++;
        if (ovf_pulses - ovf_base !== 1) begin
            n_fail++;
            $display("FAIL overflow_pulses: got %0d required 1", ovf_pulses - ovf_base);
        end
        for (int p = 0; p < 4; p++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: vld=%b info=%h required info=%h",
                         p, ip_checksum_vld, observed(), exp);
            end
            pop();
        end
        n_checks++;
        if (ip_checksum_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: vld=%b required 0", ip_checksum_vld);
        end

        // Refill, then push the fifth result on the same edge as a pop
        exp_q.delete();
        ovf_base = ovf_pulses;
        for (int p = 0; p < 5; p++) begin
            make_hdr(h, 8'h45, 8'($urandom), $urandom_range(1, 0) == 1);
            n = $urandom_range(10, 7);
            exp_q.push_back(model(h, n));
            build_pkt(h, n, 1);
            for (int i = 0; i < pkt_d.size(); i++) begin
                if (p == 4 && i == 6) rd_preprocess_info = 1'b1;
                put(pkt_d[i], pkt_c[i]);
                rd_preprocess_info = 1'b0;
            end
        end
        void'(exp_q.pop_front());
        idle(2);
        n_checks++;
        if (ovf_pulses !== ovf_base) begin
            n_fail++;
            $display("FAIL full_push_pop_ovf: pulses=%0d required 0", ovf_pulses - ovf_base);
        end
        for (int p = 0; p < 4; p++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
                n_fail++;
                $display("FAIL full_push_pop[%0d]: vld=%b info=%h required info=%h",
                         p, ip_checksum_vld, observed(), exp);
            end
            pop();
        end
        n_checks++;
        if (ip_checksum_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop_count: vld=%b required 0", ip_checksum_vld);
        end
    endtask

    task automatic test_runt();
        logic [15:0] h [10];
        for (int n = 2; n <= 4; n++) begin
            make_hdr(h, 8'h45, 8'h40, 1'b1);
            build_pkt(h, n, 1);
            send_pkt(1'b0);
            n_checks++;
            if (ip_checksum_vld !== 1'b1 || observed() !== c_RUNT) begin
                n_fail++;
                $display("FAIL runt[%0d]: vld=%b info=%h required vld=1 info=%h",
                         n, ip_checksum_vld, observed(), c_RUNT);
            end
            pop();
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] h [10];
        info_t exp;
        make_hdr(h, 8'h45, 8'h20, 1'b1);
        build_pkt(h, 8, 1);
        send_pkt(1'b0);
        make_hdr(h, 8'h45, 8'h20, 1'b1);
        build_pkt(h, 8, 1);
        for (int i = 0; i < 3; i++) put(pkt_d[i], pkt_c[i]);
        reset = 1'b1;
        put(pkt_d[3], pkt_c[3]);
        reset = 1'b0;
        n_checks++;
        if ({ip_checksum_vld, observed(), info_fifo_overflow} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got %h required 0",
                     {ip_checksum_vld, observed(), info_fifo_overflow});
        end
        make_hdr(h, 8'h45, 8'h80, 1'b1);
        exp = model(h, 9);
        build_pkt(h, 9, 1);
        send_pkt(1'b1);
        n_checks++;
        if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_next: vld=%b info=%h required vld=1 info=%h",
                     ip_checksum_vld, observed(), exp);
        end
        pop();
        n_checks++;
        if (ip_checksum_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_single: vld=%b required 0", ip_checksum_vld);
        end
    endtask

    task automatic test_random();
        logic [15:0] h [10];
        logic [7:0]  vi, ttl;
        info_t exp;
        int    n, ovf_base;
        ovf_base = ovf_pulses;
        exp_q.delete();
        for (int p = 0; p < 40; p++) begin
            vi  = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h45;
            ttl = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(2, 0)) : 8'($urandom);
            make_hdr(h, vi, ttl, $urandom_range(3, 0) != 0);
            n = ($urandom_range(6, 0) == 0) ? $urandom_range(4, 2) : $urandom_range(12, 7);
            exp_q.push_back(model(h, n));
            build_pkt(h, n, $urandom_range(2, 1));
            send_pkt(1'b1);
            if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 1));
            while (exp_q.size() >= 4 || (exp_q.size() > 0 && $urandom_range(1, 0) == 1)) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
                    n_fail++;
                    $display("FAIL random_pkt[%0d]: vld=%b info=%h required info=%h",
                             p, ip_checksum_vld, observed(), exp);
                end
                pop();
            end
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (ip_checksum_vld !== 1'b1 || observed() !== exp) begin
                n_fail++;
                $display("FAIL random_drain: vld=%b info=%h required info=%h",
                         ip_checksum_vld, observed(), exp);
            end
            pop();
        end
        n_checks++;
        if (ip_checksum_vld !== 1'b0 || ovf_pulses !== ovf_base) begin
            n_fail++;
            $display("FAIL random_end: vld=%b ovf_pulses=%0d required 0/0",
                     ip_checksum_vld, ovf_pulses - ovf_base);
        end
    endtask

    initial begin
        reset              = 1'b1;
        in_wr              = 1'b0;
        in_data            = 64'h0;
        in_ctrl            = 8'h00;
        rd_preprocess_info = 1'b0;
        test_reset();
        test_valid();
        test_bad_checksum();
        test_ttl_options();
        test_back_to_back();
        test_runt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
